shift_unit: RTL and testbench
=============================

SHIFT_UNIT -- requirements
Module: shift_unit

Interface
REQ-001 Parameter WIDTH, default 32, operand/result width; SHALL be a power of two in 8..64.
REQ-002 Parameter SHW, default $clog2(WIDTH), shift-amount width and stage count L.
REQ-003 clock  input  1  sole clock, all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 ctrl_shift  input  1  start request, sampled on rising edge.
REQ-006 data_operandA  input  WIDTH  value to shift, captured with start.
REQ-007 shamt  input  SHW  shift amount, captured with start.
REQ-008 op  input  2  mode, captured with start: 00 SLL, 01 SRL, 10 SRA, 11 ROL.
REQ-009 data_result  output  WIDTH  shift result, valid while data_resultRDY high and held until the next accepted start.
REQ-010 data_resultRDY  output  1  one-cycle completion pulse.
REQ-011 busy  output  1  high while an operation is in flight.
REQ-012 data_exception  output  1  high with data_resultRDY when op is unsupported.

Function
REQ-013 FSM states IDLE, SHIFT, DONE; busy SHALL equal (state==SHIFT).
REQ-014 Start accepted when ctrl_shift high at an edge in IDLE or DONE: capture operand/shamt/op, stage counter 0, go to SHIFT.
REQ-015 ctrl_shift while in SHIFT SHALL be ignored, with no effect on the in-flight operation.
REQ-016 In SHIFT, edge k (k=0..L-1) SHALL apply stage 2^(L-1-k) iff shamt bit L-1-k is set; MSB stage first.
REQ-017 SLL/SRL fill with zeros, SRA fills with captured operand bit WIDTH-1, ROL wraps MSBs into LSBs.
REQ-018 After the L-th stage edge the FSM SHALL enter DONE; DONE lasts exactly one cycle, then IDLE unless a new start is accepted.
REQ-019 data_resultRDY SHALL be high exactly in the DONE cycle, i.e. L edges after the start-sampling edge (5 for WIDTH=32).
REQ-020 Latency SHALL be fixed at L regardless of shamt, including shamt=0, where result equals the operand.
REQ-021 A start in the DONE cycle SHALL be accepted and does not shorten the data_resultRDY pulse.
REQ-022 Input changes after the capture edge SHALL NOT affect the result.

Reset
REQ-023 Reset SHALL force IDLE, data_result=0, data_resultRDY=0, busy=0, data_exception=0, counter=0.
REQ-024 Reset mid-operation SHALL abort it with no data_resultRDY pulse; the first edge after release accepts a start normally.

Configuration
REQ-025 Macro SHIFT_ROTATE_EN defined: op 11 performs ROL and data_exception stays 0.
REQ-026 Macro SHIFT_ROTATE_EN undefined: op 11 runs full latency, then data_result=0 and data_exception=1 in the DONE cycle.

Structure
REQ-027 Shared package SHALL hold the op encodings (SHIFT_SLL, SHIFT_SRL, SHIFT_SRA, SHIFT_ROL) and the FSM state typedef.
REQ-028 One sub-module shift_stage (combinational, parameters WIDTH and DIST, inputs value/enable/op) SHALL be reused for each stage step; the stage counter selects DIST.

Verification
REQ-029 WIDTH=32, A=0x000000FF, shamt=8, SLL -> data_result=0x0000FF00 with data_resultRDY 5 edges after start.
REQ-030 A=0x80000000, shamt=31, SRA -> 0xFFFFFFFF; same with SRL -> 0x00000001.
REQ-031 With SHIFT_ROTATE_EN: A=0x80000001, shamt=4, ROL -> 0x00000018. Without it: result 0, data_exception=1.
REQ-032 A=0x12345678, shamt=0, SRL -> 0x12345678 after full 5-cycle latency; a start pulsed while busy is ignored and yields a single data_resultRDY.
REQ-033 Reset asserted 2 cycles into an operation -> all outputs 0 immediately and no data_resultRDY. A start at the first post-reset edge with A=0x1, shamt=1, SLL -> 0x2.
REQ-034 Back-to-back start in the DONE cycle -> two data_resultRDY pulses exactly 6 cycles apart, each with the correct result.

Source files
------------

// File: rtl/shift_unit_pkg.sv
// shift_unit_pkg: op encodings and FSM state type shared by the shift unit files.
package shift_unit_pkg;
    localparam logic [1:0] SHIFT_SLL = 2'b00;
    localparam logic [1:0] SHIFT_SRL = 2'b01;
    localparam logic [1:0] SHIFT_SRA = 2'b10;
    localparam logic [1:0] SHIFT_ROL = 2'b11;
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
endpackage

// File: rtl/shift_unit_stage.sv
// shift_stage: one conditional fixed-distance shift/rotate step.
module shift_stage
    import shift_unit_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DIST  = 1
) (
    input  logic [WIDTH-1:0] value,
    input  logic             enable,
    input  logic [1:0]       op,
    output logic [WIDTH-1:0] result
);
    // The MSB of a partially shifted SRA value still equals the original sign bit.
    always_comb
        result = !enable ? value :
                 op == SHIFT_SLL ? {value[WIDTH-1-DIST:0], {DIST{1'b0}}} :
                 op == SHIFT_SRL ? {{DIST{1'b0}}, value[WIDTH-1:DIST]} :
                 op == SHIFT_SRA ? {{DIST{value[WIDTH-1]}}, value[WIDTH-1:DIST]} :
                                   {value[WIDTH-1-DIST:0], value[WIDTH-1:WIDTH-DIST]};
endmodule

// File: rtl/shift_unit.sv
// shift_unit: multi-cycle barrel shifter, one stage per cycle, MSB stage first.
// Define SHIFT_ROTATE_EN to support ROL; otherwise op 11 reports data_exception.
module shift_unit
    import shift_unit_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             ctrl_shift,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [SHW-1:0]   shamt,
    input  logic [1:0]       op,
    output logic [WIDTH-1:0] data_result,
    output logic             data_resultRDY,
    output logic             busy,
    output logic             data_exception
);
    state_t state, next;
    logic [SHW-1:0] cnt, sh;
    logic [1:0] opr;
    logic [WIDTH-1:0] acc, stage_sel;
    logic [WIDTH-1:0] stage_out [SHW];
    logic start, last, unsupported;

    for (genvar i = 0; i < SHW; i++) begin : g_stage
        shift_stage #(.WIDTH(WIDTH), .DIST(2 ** (SHW - 1 - i))) u_stage (
            .value(acc),
            .enable(sh[SHW-1-i]),
            .op(opr),
            .result(stage_out[i])
        );
    end

`ifdef SHIFT_ROTATE_EN
    assign unsupported = 1'b0;
`else
    assign unsupported = opr == SHIFT_ROL;
`endif

    assign start = ctrl_shift && state != SHIFT;
    assign last  = cnt == SHW'(SHW - 1);

    always_comb begin
        stage_sel = acc;
        for (int k = 0; k < SHW; k++)
            if (cnt == SHW'(k)) stage_sel = stage_out[k];
    end

    always_ff @(posedge clock or posedge reset)
        if (reset) state <= IDLE;
        else state <= next;

    always_comb
        next = state == SHIFT ? (last ? DONE : SHIFT) :
               ctrl_shift     ? SHIFT : IDLE;

    always_ff @(posedge clock or posedge reset)
        if (reset) begin
            acc <= '0;
            cnt <= '0;
            sh  <= '0;
            opr <= SHIFT_SLL;
        end else if (start) begin
            acc <= data_operandA;
            cnt <= '0;
            sh  <= shamt;
            opr <= op;
        end else if (state == SHIFT) begin
            acc <= (last && unsupported) ? '0 : stage_sel;
            cnt <= cnt + 1'b1;
        end

    always_comb begin
        data_result    = acc;
        data_resultRDY = state == DONE;
        busy           = state == SHIFT;
        data_exception = state == DONE && unsupported;
    end
endmodule

// File: tb/tb_shift_unit.sv
// tb_shift_unit: directed self-checking bench for shift_unit at WIDTH=32.
module tb_shift_unit;
    import shift_unit_pkg::*;
    logic clock = 1'b0, reset = 1'b1, ctrl_shift = 1'b0;
    logic [31:0] data_operandA = '0;
    logic [4:0] shamt = '0;
    logic [1:0] op = SHIFT_SLL;
    logic [31:0] data_result;
    logic data_resultRDY, busy, data_exception;
    int checks = 0, errors = 0, n = 0, pulses = 0;

    shift_unit #(.WIDTH(32)) dut (
        .clock(clock), .reset(reset), .ctrl_shift(ctrl_shift),
        .data_operandA(data_operandA), .shamt(shamt), .op(op),
        .data_result(data_result), .data_resultRDY(data_resultRDY),
        .busy(busy), .data_exception(data_exception)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Drive a start, then scramble inputs right after the capture edge.
    task automatic start_op(input logic [31:0] a, input logic [4:0] s, input logic [1:0] o);
        @(negedge clock);
        data_operandA = a; shamt = s; op = o; ctrl_shift = 1'b1;
        @(posedge clock); #1;
        ctrl_shift = 1'b0; data_operandA = ~a; shamt = ~s; op = SHIFT_SLL;
    endtask

    task automatic wait_rdy(output int cycles);
        cycles = 0;
        while (cycles < 20 && !data_resultRDY) begin
            @(posedge clock); #1;
            cycles++;
        end
    endtask

    initial begin
        #12;
        chk("reset_result", data_result, 32'h0);
        chk("reset_rdy", {31'b0, data_resultRDY}, 32'h0);
        chk("reset_busy", {31'b0, busy}, 32'h0);
        chk("reset_exc", {31'b0, data_exception}, 32'h0);
        @(negedge clock); reset = 1'b0;

        start_op(32'h0000_00FF, 5'd8, SHIFT_SLL);
        chk("sll_busy", {31'b0, busy}, 32'h1);
        wait_rdy(n);
        chk("sll_latency", n, 32'd5);
        chk("sll_result", data_result, 32'h0000_FF00);
        chk("sll_exc", {31'b0, data_exception}, 32'h0);
        @(posedge clock); #1;
        chk("sll_rdy_pulse", {31'b0, data_resultRDY}, 32'h0);
        chk("sll_hold", data_result, 32'h0000_FF00);

        start_op(32'h8000_0000, 5'd31, SHIFT_SRA);
        wait_rdy(n);
        chk("sra_latency", n, 32'd5);
        chk("sra_result", data_result, 32'hFFFF_FFFF);

        start_op(32'h8000_0000, 5'd31, SHIFT_SRL);
        wait_rdy(n);
        chk("srl_result", data_result, 32'h0000_0001);

        start_op(32'h8000_0001, 5'd4, SHIFT_ROL);
        wait_rdy(n);
        chk("rol_latency", n, 32'd5);
`ifdef SHIFT_ROTATE_EN
        chk("rol_result", data_result, 32'h0000_0018);
        chk("rol_exc", {31'b0, data_exception}, 32'h0);
`else
        chk("rol_result", data_result, 32'h0);
        chk("rol_exc", {31'b0, data_exception}, 32'h1);
`endif
        @(posedge clock); #1;
        chk("rol_exc_clear", {31'b0, data_exception}, 32'h0);

        // shamt=0 with a start request pulsed while busy
        start_op(32'h1234_5678, 5'd0, SHIFT_SRL);
        @(posedge clock); #1;
        data_operandA = 32'hDEAD_BEEF; shamt = 5'd3; op = SHIFT_SLL; ctrl_shift = 1'b1;
        @(posedge clock); #1;
        ctrl_shift = 1'b0;
        wait_rdy(n);
        chk("zero_latency", n + 2, 32'd5);
        chk("zero_result", data_result, 32'h1234_5678);
        pulses = 0;
        repeat (8) begin
            @(posedge clock); #1;
            if (data_resultRDY) pulses++;
        end
        chk("busy_start_ignored", pulses, 32'd0);

        // reset two cycles into an operation
        start_op(32'h0000_0055, 5'd3, SHIFT_SLL);
        @(posedge clock); #2;
        reset = 1'b1;
        #1;
        chk("abort_result", data_result, 32'h0);
        chk("abort_busy", {31'b0, busy}, 32'h0);
        chk("abort_rdy", {31'b0, data_resultRDY}, 32'h0);
        @(negedge clock);
        reset = 1'b0; data_operandA = 32'h1; shamt = 5'd1; op = SHIFT_SLL; ctrl_shift = 1'b1;
        @(posedge clock); #1;
        ctrl_shift = 1'b0;
        chk("post_reset_busy", {31'b0, busy}, 32'h1);
        wait_rdy(n);
        chk("post_reset_latency", n, 32'd5);
        chk("post_reset_result", data_result, 32'h2);

        // back-to-back start in the DONE cycle
        start_op(32'h0000_00FF, 5'd8, SHIFT_SLL);
        wait_rdy(n);
        chk("b2b_first_result", data_result, 32'h0000_FF00);
        data_operandA = 32'h0000_00F0; shamt = 5'd4; op = SHIFT_SRL; ctrl_shift = 1'b1;
        @(posedge clock); #1;
        ctrl_shift = 1'b0; data_operandA = 32'hFFFF_FFFF;
        chk("b2b_pulse_len", {31'b0, data_resultRDY}, 32'h0);
        chk("b2b_busy", {31'b0, busy}, 32'h1);
        wait_rdy(n);
        chk("b2b_spacing", n + 1, 32'd6);
        chk("b2b_second_result", data_result, 32'h0000_000F);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
